ram_sdp_bypass: RTL and testbench

Parametrised simple dual-port synchronous RAM with one write port and one read port. It is the next generation of the team's basic RAM and adds:
- byte-lane write enables
- a read enable with a `q_valid` flag
- a selectable read-during-write mode (old or new data)
- an optional output pipeline register
- a post-reset clear sequencer that zeroes the whole array

It is the storage primitive under the project's FIFOs and line buffers.

---
 rtl/ram_sdp_bypass_if.sv | 31 +++
 rtl/ram_sdp_bypass.sv | 118 +++++++++++
 tb/tb_ram_sdp_bypass.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sdp_bypass_if.sv
// Bus bundle for ram_sdp_bypass: the write port, the read port and the
// read-result/status signals that go back to the requester.
//   master : drives data, write_addr, we, be, read_addr, re; receives q, q_valid, busy
//   slave  : the RAM side of the same bundle
interface ram_sdp_bypass_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int BYTE_W     = 8
);
    localparam int NB = DATA_WIDTH / BYTE_W;

    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  we;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  re;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  busy;

    modport master (
        output data, write_addr, we, be, read_addr, re,
        input  q, q_valid, busy
    );

    modport slave (
        input  data, write_addr, we, be, read_addr, re,
        output q, q_valid, busy
    );
endinterface

// File: rtl/ram_sdp_bypass.sv
// Simple dual-port synchronous RAM (one write port, one read port) with
// byte-lane write enables, read enable plus q_valid, selectable
// read-during-write behaviour, optional output register and a post-reset
// zeroing sweep.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : ram_sdp_bypass_if.slave
//         data/write_addr/we/be  - write request, be[i] covers data[i*BYTE_W +: BYTE_W]
//         read_addr/re           - read request
//         q/q_valid              - registered read data and its one-cycle valid pulse
//         busy                   - clear sweep running, requests ignored
module ram_sdp_bypass #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int BYTE_W     = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input logic            clk,
    input logic            rst,
    ram_sdp_bypass_if.slave bus
);
    localparam int unsigned NB    = DATA_WIDTH / BYTE_W;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    if ((DATA_WIDTH % BYTE_W) != 0) begin : g_bad_width
        $error("ram_sdp_bypass: DATA_WIDTH must be a multiple of BYTE_W");
    end

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_word;

    assign rd_fire  = (state == ST_READY) && bus.re;
    assign bus.busy = (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
            if (clr_ptr == '1) begin
                state <= ST_READY;
            end
        end
    end

    // Array has no reset: contents survive rst except where the sweep rewrites them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (bus.we) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (bus.be[i]) begin
                        mem[bus.write_addr][i*BYTE_W +: BYTE_W] <= bus.data[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    // NEW mode: a same-address write on this edge is merged lane-by-lane into
    // the word being captured, since the array itself still holds the old word.
    always_comb begin
        rd_word = mem[bus.read_addr];
        if (RDW_MODE != 0 && bus.we && bus.read_addr == bus.write_addr) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (bus.be[i]) begin
                    rd_word[i*BYTE_W +: BYTE_W] = bus.data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  s1_valid;
        logic [DATA_WIDTH-1:0] s1_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid    <= 1'b0;
                s1_data     <= '0;
                bus.q_valid <= 1'b0;
                bus.q       <= '0;
            end else begin
                s1_valid    <= rd_fire;
                if (rd_fire) begin
                    s1_data <= rd_word;
                end
                bus.q_valid <= s1_valid;
                if (s1_valid) begin
                    bus.q <= s1_data;
                end
            end
        end
    end else begin : g_out_direct
        always_ff @(posedge clk) begin
            if (rst) begin
                bus.q_valid <= 1'b0;
                bus.q       <= '0;
            end else begin
                bus.q_valid <= rd_fire;
                if (rd_fire) begin
                    bus.q <= rd_word;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_sdp_bypass.sv
// Bench for ram_sdp_bypass: three instances share one stimulus stream
//   dut0: RDW_MODE=0 OUT_REG=0 INIT_CLEAR=1
//   dut1: RDW_MODE=1 OUT_REG=1 INIT_CLEAR=1
//   dut2: RDW_MODE=0 OUT_REG=0 INIT_CLEAR=0
// Every cycle all three are compared with a word-array reference model;
// directed table and hand-written sequences add explicit expected values.
module tb_ram_sdp_bypass;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, re = 1'b0;
    logic [1:0]  be = '0;
    logic [15:0] data = '0;
    logic [4:0]  wa = '0, ra = '0;

    always #5 clk = ~clk;

    ram_sdp_bypass_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .BYTE_W(8)) if0 ();
    ram_sdp_bypass_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .BYTE_W(8)) if1 ();
    ram_sdp_bypass_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .BYTE_W(8)) if2 ();

    assign if0.data = data; assign if0.write_addr = wa; assign if0.we = we;
    assign if0.be = be; assign if0.read_addr = ra; assign if0.re = re;
    assign if1.data = data; assign if1.write_addr = wa; assign if1.we = we;
    assign if1.be = be; assign if1.read_addr = ra; assign if1.re = re;
    assign if2.data = data; assign if2.write_addr = wa; assign if2.we = we;
    assign if2.be = be; assign if2.read_addr = ra; assign if2.re = re;

    ram_sdp_bypass #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .BYTE_W(8),
                     .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(1))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    ram_sdp_bypass #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .BYTE_W(8),
                     .RDW_MODE(1), .OUT_REG(1), .INIT_CLEAR(1))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    ram_sdp_bypass #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .BYTE_W(8),
                     .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(0))
        dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic [15:0] aq [3];
    logic        aqv [3];
    logic        abusy [3];
    assign aq[0] = if0.q; assign aqv[0] = if0.q_valid; assign abusy[0] = if0.busy;
    assign aq[1] = if1.q; assign aqv[1] = if1.q_valid; assign abusy[1] = if1.busy;
    assign aq[2] = if2.q; assign aqv[2] = if2.q_valid; assign abusy[2] = if2.busy;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input logic [15:0] act, input logic [15:0] exp,
                         input logic [15:0] mask);
        checks++;
        if (((act ^ exp) & mask) !== 16'h0000) begin
            failures++;
            $display("FAIL %s: got %h expected %h (known-bit mask %h)", name, act, exp, mask);
        end
    endtask

    // Reference model: per-instance word array with per-byte "known" flags
    // (dut2 is never cleared, so unwritten bytes are unknown), a busy cycle
    // counter and a list of expected outputs.
    int          m_rdw [3] = '{0, 1, 0};
    int          m_lat [3] = '{1, 2, 1};
    int          m_clr [3] = '{1, 1, 0};
    logic [15:0] m_mem [3][32];
    logic [1:0]  m_kn  [3][32];
    int          m_busy [3];
    logic        m_s1v [3];
    logic [15:0] m_s1d [3];
    logic [1:0]  m_s1k [3];
    logic [15:0] e_q  [3];
    logic [1:0]  e_qk [3];
    logic        e_qv [3];
    bit          m_init = 1'b0;

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            logic        rv;
            logic [15:0] rd;
            logic [1:0]  rk;
            rv = 1'b0; rd = '0; rk = '0;
            if (rst) begin
                m_busy[k] = (m_clr[k] != 0) ? 32 : 0;
                m_s1v[k] = 1'b0;
                e_q[k] = '0; e_qk[k] = 2'b11; e_qv[k] = 1'b0;
            end else begin
                if (m_busy[k] > 0) begin
                    m_mem[k][32 - m_busy[k]] = '0;
                    m_kn[k][32 - m_busy[k]]  = 2'b11;
                    m_busy[k]--;
                end else begin
                    if (re) begin
                        rv = 1'b1;
                        rd = m_mem[k][ra];
                        rk = m_kn[k][ra];
                        if (m_rdw[k] == 1 && we && ra == wa) begin
                            for (int i = 0; i < 2; i++) begin
                                if (be[i]) begin
                                    rd[i*8 +: 8] = data[i*8 +: 8];
                                    rk[i] = 1'b1;
                                end
                            end
                        end
                    end
                    if (we) begin
                        for (int i = 0; i < 2; i++) begin
                            if (be[i]) begin
                                m_mem[k][wa][i*8 +: 8] = data[i*8 +: 8];
                                m_kn[k][wa][i] = 1'b1;
                            end
                        end
                    end
                end
                if (m_lat[k] == 1) begin
                    e_qv[k] = rv;
                    if (rv) begin e_q[k] = rd; e_qk[k] = rk; end
                end else begin
                    e_qv[k] = m_s1v[k];
                    if (m_s1v[k]) begin e_q[k] = m_s1d[k]; e_qk[k] = m_s1k[k]; end
                    m_s1v[k] = rv; m_s1d[k] = rd; m_s1k[k] = rk;
                end
            end
        end
        if (rst) m_init = 1'b1;
    endtask

    task automatic check_all();
        if (m_init) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model dut%0d.busy", k), 32'(abusy[k]), 32'(m_busy[k] > 0));
                chk($sformatf("model dut%0d.q_valid", k), 32'(aqv[k]), 32'(e_qv[k]));
                chk_q($sformatf("model dut%0d.q", k), aq[k], e_q[k],
                      {{8{e_qk[k][1]}}, {8{e_qk[k][0]}}});
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] b,
                         input logic [15:0] d, input logic [4:0] a,
                         input logic rr, input logic [4:0] rad);
        rst = r; we = w; be = b; data = d; wa = a; re = rr; ra = rad;
    endtask

    task automatic count_busy(input int k, output int n);
        n = 0;
        while (abusy[k] && n < 100) begin
            n++;
            cycle();
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [15:0] data;
        logic [4:0]  wa;
        logic        re;
        logic [4:0]  ra;
        logic        qv0;
        logic [15:0] q0;
        logic        qv1;
        logic [15:0] q1;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // byte enables + read-during-write; dut0 = OLD/latency1, dut1 = NEW/latency2
        //         we   be     data     wa  re  ra   qv0 q0        qv1 q1
        tbl[0]  = '{1, 2'b11, 16'hA1B2, 7,  0, 0,   0, 16'h0000, 0, 16'h0000};
        tbl[1]  = '{1, 2'b01, 16'hFFFF, 7,  0, 0,   0, 16'h0000, 0, 16'h0000};
        tbl[2]  = '{1, 2'b00, 16'h0000, 7,  0, 0,   0, 16'h0000, 0, 16'h0000};
        tbl[3]  = '{0, 2'b00, 16'h0000, 0,  1, 7,   1, 16'hA1FF, 0, 16'h0000};
        tbl[4]  = '{1, 2'b11, 16'h1234, 9,  0, 0,   0, 16'hA1FF, 1, 16'hA1FF};
        tbl[5]  = '{1, 2'b10, 16'hABCD, 9,  1, 9,   1, 16'h1234, 0, 16'hA1FF};
        tbl[6]  = '{0, 2'b00, 16'h0000, 0,  1, 9,   1, 16'hAB34, 1, 16'hAB34};
        tbl[7]  = '{1, 2'b11, 16'hBEEF, 10, 1, 9,   1, 16'hAB34, 1, 16'hAB34};
        tbl[8]  = '{0, 2'b00, 16'h0000, 0,  1, 10,  1, 16'hBEEF, 1, 16'hAB34};
        tbl[9]  = '{0, 2'b00, 16'h0000, 0,  0, 0,   0, 16'hBEEF, 1, 16'hBEEF};
        tbl[10] = '{0, 2'b00, 16'h0000, 0,  0, 0,   0, 16'hBEEF, 0, 16'hBEEF};

        // reset values
        drive(1, 0, 2'b00, 16'h0, 0, 0, 0);
        cycle();
        chk("rst dut0.busy", 32'(abusy[0]), 1);
        chk("rst dut1.busy", 32'(abusy[1]), 1);
        chk("rst dut2.busy", 32'(abusy[2]), 0);
        chk("rst dut1.q", 32'(aq[1]), 0);
        chk("rst dut1.q_valid", 32'(aqv[1]), 0);

        // clear sweep: busy for 32 cycles, write/read of address 3 ignored
        drive(0, 1, 2'b11, 16'hFFFF, 3, 1, 3);
        count_busy(0, n);
        chk("clear length", 32'(n), 32);
        drive(0, 0, 2'b00, 16'h0, 0, 0, 0);
        cycle();
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 2'b00, 16'h0, 0, 1, 5'(i));
            cycle();
            chk($sformatf("cleared[%0d] q_valid", i), 32'(aqv[0]), 1);
            chk($sformatf("cleared[%0d] q", i), 32'(aq[0]), 0);
        end
        drive(0, 0, 2'b00, 16'h0, 0, 0, 0);
        cycle();
        cycle();

        // table-driven byte-enable and read-during-write vectors
        for (int i = 0; i < 11; i++) begin
            drive(0, tbl[i].we, tbl[i].be, tbl[i].data, tbl[i].wa, tbl[i].re, tbl[i].ra);
            cycle();
            chk($sformatf("tbl[%0d] dut0.q_valid", i), 32'(aqv[0]), 32'(tbl[i].qv0));
            chk($sformatf("tbl[%0d] dut0.q", i), 32'(aq[0]), 32'(tbl[i].q0));
            chk($sformatf("tbl[%0d] dut1.q_valid", i), 32'(aqv[1]), 32'(tbl[i].qv1));
            chk($sformatf("tbl[%0d] dut1.q", i), 32'(aq[1]), 32'(tbl[i].q1));
        end

        // streaming on the 2-cycle-latency instance
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 2'b11, 16'(16'h0010 + i), 5'(i), 0, 0);
            cycle();
        end
        for (int j = 0; j < 8; j++) begin
            logic [15:0] eq;
            drive(0, 0, 2'b00, 16'h0, 0, j < 5, 5'(j));
            cycle();
            eq = (j == 0) ? 16'hBEEF : (j <= 5) ? 16'(16'h0010 + j - 1) : 16'h0014;
            chk($sformatf("stream[%0d] q_valid", j), 32'(aqv[1]), 32'(j >= 1 && j <= 5));
            chk($sformatf("stream[%0d] q", j), 32'(aq[1]), 32'(eq));
        end

        // reset with a read in flight, then again with the sweep at pointer 20
        drive(0, 0, 2'b00, 16'h0, 0, 1, 2);
        cycle();
        drive(1, 0, 2'b00, 16'h0, 0, 0, 0);
        cycle();
        chk("midrst q_valid", 32'(aqv[1]), 0);
        chk("midrst q", 32'(aq[1]), 0);
        drive(0, 1, 2'b11, 16'hFFFF, 25, 1, 2);
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("inflight dropped", 32'(aqv[1]), 0);
        end
        drive(1, 0, 2'b00, 16'h0, 0, 0, 0);
        cycle();
        drive(0, 0, 2'b00, 16'h0, 0, 1, 21);
        count_busy(1, n);
        chk("restarted clear length", 32'(n), 32);
        chk("restarted q", 32'(aq[1]), 0);

        // no-clear instance: usable on the first edge after reset
        drive(1, 0, 2'b00, 16'h0, 0, 0, 0);
        cycle();
        drive(0, 1, 2'b11, 16'h5555, 31, 0, 0);
        cycle();
        drive(0, 0, 2'b00, 16'h0, 0, 1, 31);
        cycle();
        chk("noclear q", 32'(aq[2]), 32'h5555);
        chk("noclear q_valid", 32'(aqv[2]), 1);
        chk("noclear busy", 32'(abusy[2]), 0);

        // randomized traffic against the model, including occasional resets
        for (int i = 0; i < 500; i++) begin
            logic [4:0] w, r;
            w = 5'($urandom_range(0, 7));
            r = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31) & 5'h0B);
            drive($urandom_range(0, 149) == 0, 1'($urandom), 2'($urandom),
                  16'($urandom), w, 1'($urandom), r);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
